// File: rtl/multi_timer.sv
`timescale 1ns/1ps
// Multi-channel timer: per-channel prescaler, up-counter with >= compare,
// one-shot/periodic modes, write-1-to-clear pending bits and a combined interrupt.

`ifndef INT_ASSERT
`define INT_ASSERT 1'b1
`endif
`ifndef INT_DEASSERT
`define INT_DEASSERT 1'b0
`endif

module multi_timer #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned PRESC_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  output logic [31:0] data_o,
  output logic        int_sig_o
);

  localparam logic [3:0] OFF_CTRL    = 4'h0;
  localparam logic [3:0] OFF_COUNT   = 4'h4;
  localparam logic [3:0] OFF_VALUE   = 4'h8;
  localparam logic [3:0] OFF_PRESC   = 4'hC;
  localparam logic [7:0] ADDR_STATUS = 8'hF0;

  logic [NUM_CH-1:0]  en, ie, pending, mode;
  logic [CNT_W-1:0]   count [NUM_CH];
  logic [CNT_W-1:0]   value [NUM_CH];
  logic [PRESC_W-1:0] presc [NUM_CH];
  logic [PRESC_W-1:0] pcnt  [NUM_CH];

  logic [NUM_CH-1:0]  tick, expiry, en_next, irq;
  logic [NUM_CH-1:0]  ctrl_wr, value_wr, presc_wr;
  logic               unused;

  assign unused = ^{addr_i[31:8], data_i};

  always_comb begin
    tick     = '0;
    expiry   = '0;
    en_next  = '0;
    irq      = '0;
    ctrl_wr  = '0;
    value_wr = '0;
    presc_wr = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ctrl_wr[i]  = we_i && (addr_i[7:0] == {4'(i), OFF_CTRL});
      value_wr[i] = we_i && (addr_i[7:0] == {4'(i), OFF_VALUE});
      presc_wr[i] = we_i && (addr_i[7:0] == {4'(i), OFF_PRESC});
      tick[i]     = en[i] && (pcnt[i] == presc[i]);
      expiry[i]   = tick[i] && (count[i] >= value[i]);
      // A CTRL write decides en outright; otherwise one-shot expiry stops the channel.
      en_next[i]  = ctrl_wr[i] ? data_i[0] : (en[i] && !(expiry[i] && !mode[i]));
      irq[i]      = pending[i] & ie[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en      <= '0;
      ie      <= '0;
      pending <= '0;
      mode    <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        count[i] <= '0;
        value[i] <= '0;
        presc[i] <= '0;
        pcnt[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (ctrl_wr[i]) begin
          ie[i]   <= data_i[1];
          mode[i] <= data_i[3];
        end
        en[i]      <= en_next[i];
        pending[i] <= expiry[i] | (pending[i] & ~(ctrl_wr[i] & data_i[2]));
        // Clearing on en_next keeps COUNT/pcnt at zero in every cycle en reads 0.
        if (!en_next[i]) begin
          count[i] <= '0;
          pcnt[i]  <= '0;
        end else if (tick[i]) begin
          pcnt[i]  <= '0;
          count[i] <= expiry[i] ? '0 : count[i] + CNT_W'(1);
        end else if (en[i]) begin
          pcnt[i]  <= pcnt[i] + PRESC_W'(1);
        end
        if (value_wr[i]) value[i] <= data_i[CNT_W-1:0];
        if (presc_wr[i]) presc[i] <= data_i[PRESC_W-1:0];
      end
    end
  end

  always_comb begin
    data_o = '0;
    if (!rst) begin
      if (addr_i[7:0] == ADDR_STATUS) data_o = 32'(irq);
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (addr_i[7:4] == 4'(i)) begin
          case (addr_i[3:0])
            OFF_CTRL:  data_o = {28'd0, mode[i], pending[i], ie[i], en[i]};
            OFF_COUNT: data_o = 32'(count[i]);
            OFF_VALUE: data_o = 32'(value[i]);
            OFF_PRESC: data_o = 32'(presc[i]);
            default:   data_o = '0;
          endcase
        end
      end
    end
  end

  assign int_sig_o = (!rst && (|irq)) ? `INT_ASSERT : `INT_DEASSERT;

endmodule

// File: doc/multi_timer.md
MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning the number of independent timer channels (legal range 1..4).
REQ-002 SHALL have parameter CNT_W, default 32, meaning the counter and compare width (legal range 8..32).
REQ-003 SHALL have parameter PRESC_W, default 16, meaning the prescaler width (legal range 1..16).
REQ-004 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port data_i  input  32  write data.
REQ-007 SHALL have port addr_i  input  32  register address; only addr_i[7:0] is decoded.
REQ-008 SHALL have port we_i  input  1  write enable; a write occurs at a clock edge with we_i=1.
REQ-009 SHALL have port data_o  output  32  combinational read data for addr_i.
REQ-010 SHALL have port int_sig_o  output  1  interrupt, `INT_ASSERT when any channel has pending=1 and ie=1, else `INT_DEASSERT.

Function
REQ-011 SHALL decode per-channel registers at addr_i[7:4]=ch (ch<NUM_CH) with offsets 0x0 CTRL, 0x4 COUNT (read-only), 0x8 VALUE, 0xC PRESC.
REQ-012 SHALL define CTRL as [0] en, [1] ie, [2] pending (write 1 to clear), [3] mode (0 one-shot, 1 periodic), with [31:4] reading 0.
REQ-013 SHALL provide STATUS at 0xF0 (read-only), bit i = pending_i & ie_i for i<NUM_CH, other bits 0.
REQ-014 SHALL return 0 for reads of unmapped offsets, channel indices >= NUM_CH, and any address while rst=1; writes to those addresses and to COUNT/STATUS SHALL be ignored.
REQ-015 SHALL zero-extend COUNT/VALUE (CNT_W) and PRESC (PRESC_W) on read, and take the low bits of data_i on write.
REQ-016 SHALL, per channel with en=1, run a prescale counter pcnt that generates tick when pcnt==PRESC, pcnt then returning to 0; otherwise pcnt increments.
REQ-017 SHALL increment COUNT by 1 on each tick, with PRESC=0 giving a tick every clock.
REQ-018 SHALL declare expiry when tick and COUNT>=VALUE; on expiry COUNT<=0 and pending<=1, and in one-shot mode en<=0, while in periodic mode en stays 1.
REQ-019 SHALL hold COUNT=0 and pcnt=0 whenever en=0.
REQ-020 SHALL, with VALUE=0, expire on every tick with COUNT remaining 0.
REQ-021 SHALL, when VALUE is written below the current COUNT, expire on the next tick (>= compare, no wrap).
REQ-022 SHALL, when a CTRL write and an expiry coincide, compute pending_next = expiry | (pending & ~data_i[2]) so that the hardware set wins, and take en/ie/mode from data_i.
REQ-023 SHALL, when a VALUE or PRESC write coincides with a tick, evaluate that tick against the old values, with the new values taking effect from the next cycle.
REQ-024 SHALL keep channels fully independent; simultaneous expiries on several channels all set their pending bits in the same cycle.
REQ-025 SHALL have int_sig_o and data_o combinational from current register state, with no additional latency.

Reset
REQ-026 SHALL, on a clock edge with rst=1, clear CTRL, COUNT, VALUE, PRESC and pcnt of every channel to 0, regardless of activity in progress.
REQ-027 SHALL hold int_sig_o=`INT_DEASSERT and data_o=0 while rst=1 and after reset until configured.

Verification
REQ-028 SHALL cover: ch0 VALUE=5, PRESC=0, CTRL=0x3 -> COUNT reads 0..5, expiry on the 6th tick, CTRL reads 0x6, int_sig_o asserted, en cleared.
REQ-029 SHALL cover: ch1 VALUE=3, PRESC=2, CTRL=0xB -> tick every 3 clocks, pending set every 12 clocks, en stays 1; write CTRL=0xF clears pending, and a coinciding expiry leaves pending=1.
REQ-030 SHALL cover: ch2 VALUE=0, PRESC=0, periodic -> pending set every cycle and COUNT constant 0.
REQ-031 SHALL cover: ch3 counting with COUNT=10, write VALUE=4 -> expiry on the next tick, COUNT<=0.
REQ-032 SHALL cover: ch0 and ch3 expiring in the same cycle with ie=1 -> STATUS at 0xF0 reads 0x9, and clearing ch0 leaves int_sig_o asserted until ch3 is cleared.
REQ-033 SHALL cover: rst asserted mid-count with pending=1 -> next cycle all registers read 0 and int_sig_o deasserted; a read of 0x50 with NUM_CH=4 returns 0.
